mario_collision_poller: RTL and testbench

- Upstream feeder for the Mario motion block: produces the four 3-bit tile polls it consumes (mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right).
- Once per frame, snapshots Mario's screen position, probes 8 points around his bounding box in the level tile RAM, and commits all four polls atomically.
- Polls are stable before the motion block's next frame_clk rising edge.

---
 rtl/mario_pkg.sv | 28 ++
 rtl/probe_addr_gen.sv | 56 +++++
 rtl/mario_collision_poller.sv | 172 +++++++++++++++++
 tb/tb_mario_collision_poller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mario_pkg.sv
// Shared types and level geometry for the Mario collision poller.
// Tile encoding, probe directions and the poller FSM states live here.
package mario_pkg;

    typedef logic [2:0] tile_t;

    localparam tile_t TILE_AIR = 3'b000;
    localparam tile_t OOB_TILE = 3'b111;

    localparam logic [9:0] HALF_SIZE = 10'd20;
    localparam logic [9:0] PROBE_GAP = 10'd2;
    localparam logic [9:0] INSET     = 10'd2;

    localparam int TILE_SHIFT      = 4;
    localparam int LEVEL_COLS_LOG2 = 8;
    localparam int LEVEL_ROWS      = 30;
    localparam int ROW_BITS        = 5;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} probe_dir_e;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} poller_state_e;

    // A poll reports the first solid tile of its probe pair; the lower index wins.
    function automatic tile_t first_solid(input tile_t a, input tile_t b);
        return (a != TILE_AIR) ? a : b;
    endfunction

endpackage

// File: rtl/probe_addr_gen.sv
// Maps a probe index and the frame snapshot to a tile RAM address,
// flagging probes that fall outside the level horizontally or vertically.
module probe_addr_gen
    import mario_pkg::*;
(
    input  logic [2:0]  idx,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic [11:0] scroll,
    output logic [12:0] addr,
    output logic        oob_x,
    output logic        oob_y
);

    localparam logic signed [13:0] X_LIMIT = 14'(1 << (LEVEL_COLS_LOG2 + TILE_SHIFT));
    localparam logic signed [13:0] Y_LIMIT = 14'(LEVEL_ROWS << TILE_SHIFT);

    // 14 bits keeps x + scroll from wrapping at the far right of the level.
    logic signed [13:0] half, gap, inset;
    logic signed [13:0] cx, cy;
    logic signed [13:0] left_x, right_x, top_y, bot_y;
    logic signed [13:0] px, py, wx;

    assign half  = $signed({4'b0, HALF_SIZE});
    assign gap   = $signed({4'b0, PROBE_GAP});
    assign inset = $signed({4'b0, INSET});
    assign cx    = $signed({4'b0, x_pos});
    assign cy    = $signed({4'b0, y_pos});

    assign left_x  = cx - half;
    assign right_x = cx + half - 14'sd1;
    assign top_y   = cy - half;
    assign bot_y   = cy + half - 14'sd1;

    always_comb begin
        px = left_x + inset;
        py = top_y - gap;
        case (idx)
            3'd0: begin px = left_x + inset;  py = top_y - gap;   end
            3'd1: begin px = right_x - inset; py = top_y - gap;   end
            3'd2: begin px = left_x + inset;  py = bot_y + gap;   end
            3'd3: begin px = right_x - inset; py = bot_y + gap;   end
            3'd4: begin px = left_x - gap;    py = top_y + inset; end
            3'd5: begin px = left_x - gap;    py = bot_y - inset; end
            3'd6: begin px = right_x + gap;   py = top_y + inset; end
            3'd7: begin px = right_x + gap;   py = bot_y - inset; end
            default: ;
        endcase
    end

    assign wx    = px + $signed({2'b0, scroll});
    assign oob_x = (wx < 14'sd0) || (wx >= X_LIMIT);
    assign oob_y = (py < 14'sd0) || (py >= Y_LIMIT);
    assign addr  = {py[TILE_SHIFT +: ROW_BITS], wx[TILE_SHIFT +: LEVEL_COLS_LOG2]};

endmodule

// File: rtl/mario_collision_poller.sv
// Once per frame, probes eight points around Mario's box in the tile RAM
// and commits the up/down/left/right polls together with a done pulse.
module mario_collision_poller
    import mario_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  Mario_X_Pos,
    input  logic [9:0]  Mario_Y_Pos,
    input  logic [11:0] Scroll_Offset,
    output logic [12:0] tile_addr,
    output logic        tile_rd,
    input  logic [2:0]  tile_data,
    output logic [2:0]  mario_poll_up,
    output logic [2:0]  mario_poll_down,
    output logic [2:0]  mario_poll_left,
    output logic [2:0]  mario_poll_right,
    output logic        poll_done
);

    genvar gi;

    poller_state_e state_reg, state_next;
    logic [2:0]    idx_reg, idx_next;

    logic frame_sync_reg, frame_prev_reg, armed_reg;
    logic start;

    logic [9:0]  x_snap_reg, y_snap_reg;
    logic [11:0] scroll_snap_reg;

    logic [12:0] gen_addr;
    logic        gen_oob_x, gen_oob_y;

    logic        rd_valid_reg, rd_oob_x_reg, rd_oob_y_reg;
    logic [2:0]  rd_idx_reg;
    tile_t       res_in;
    tile_t       res_reg    [8];
    tile_t       res_merged [8];
    tile_t       poll_word  [4];

    tile_t poll_up_reg, poll_down_reg, poll_left_reg, poll_right_reg;
    logic  poll_done_reg;

    // Arming on a raw high level means a reset released while frame_clk is
    // already low cannot masquerade as a falling edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_sync_reg <= 1'b1;
            frame_prev_reg <= 1'b1;
            armed_reg      <= 1'b0;
        end else begin
            frame_sync_reg <= frame_clk;
            frame_prev_reg <= frame_sync_reg;
            armed_reg      <= armed_reg | frame_clk;
        end
    end

    assign start = armed_reg & frame_prev_reg & ~frame_sync_reg;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg       <= IDLE;
            idx_reg         <= 3'd0;
            x_snap_reg      <= 10'd0;
            y_snap_reg      <= 10'd0;
            scroll_snap_reg <= 12'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (state_reg == IDLE && start) begin
                x_snap_reg      <= Mario_X_Pos;
                y_snap_reg      <= Mario_Y_Pos;
                scroll_snap_reg <= Scroll_Offset;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                idx_next = 3'd0;
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                idx_next = idx_reg + 3'd1;
                if (idx_reg == 3'd7) state_next = DRAIN;
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    probe_addr_gen u_probe_addr_gen (
        .idx    (idx_reg),
        .x_pos  (x_snap_reg),
        .y_pos  (y_snap_reg),
        .scroll (scroll_snap_reg),
        .addr   (gen_addr),
        .oob_x  (gen_oob_x),
        .oob_y  (gen_oob_y)
    );

    // Out-of-range probes still read so every sweep has the same latency.
    assign tile_rd   = (state_reg == ISSUE);
    assign tile_addr = tile_rd ? gen_addr : 13'd0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_valid_reg <= 1'b0;
            rd_idx_reg   <= 3'd0;
            rd_oob_x_reg <= 1'b0;
            rd_oob_y_reg <= 1'b0;
        end else begin
            rd_valid_reg <= tile_rd;
            rd_idx_reg   <= idx_reg;
            rd_oob_x_reg <= gen_oob_x;
            rd_oob_y_reg <= gen_oob_y;
        end
    end

    // Off the level sides reads as solid; above or below the level reads as air.
    assign res_in = rd_oob_x_reg ? OOB_TILE :
                    rd_oob_y_reg ? TILE_AIR : tile_data;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 8; i++) res_reg[i] <= TILE_AIR;
        end else if (rd_valid_reg) begin
            res_reg[rd_idx_reg] <= res_in;
        end
    end

    // Probe 7 is still on tile_data in DRAIN, so the commit sees it bypassed in.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_res
            assign res_merged[gi] = (rd_valid_reg && rd_idx_reg == 3'(gi)) ? res_in : res_reg[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_poll
            assign poll_word[gi] = first_solid(res_merged[2*gi], res_merged[2*gi+1]);
        end
    endgenerate

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            poll_up_reg    <= TILE_AIR;
            poll_down_reg  <= TILE_AIR;
            poll_left_reg  <= TILE_AIR;
            poll_right_reg <= TILE_AIR;
            poll_done_reg  <= 1'b0;
        end else begin
            poll_done_reg <= 1'b0;
            if (state_reg == DRAIN) begin
                poll_up_reg    <= poll_word[UP];
                poll_down_reg  <= poll_word[DOWN];
                poll_left_reg  <= poll_word[LEFT];
                poll_right_reg <= poll_word[RIGHT];
                poll_done_reg  <= 1'b1;
            end
        end
    end

    assign mario_poll_up    = poll_up_reg;
    assign mario_poll_down  = poll_down_reg;
    assign mario_poll_left  = poll_left_reg;
    assign mario_poll_right = poll_right_reg;
    assign poll_done        = poll_done_reg;

endmodule

// File: tb/tb_mario_collision_poller.sv
// Sweeps the poller over directed and random scenes and compares each
// commit with a probe-geometry model evaluated over the bench's tile RAM.
module tb_mario_collision_poller;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  Mario_X_Pos;
    logic [9:0]  Mario_Y_Pos;
    logic [11:0] Scroll_Offset;
    logic [12:0] tile_addr;
    logic        tile_rd;
    logic [2:0]  tile_data = 3'd0;
    logic [2:0]  mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right;
    logic        poll_done;

    logic [2:0]  mem [0:8191];
    int          addr_log [$];
    int          done_cnt = 0;
    int          vec_cnt  = 0;
    int          err_cnt  = 0;

    always #5 Clk = ~Clk;

    mario_collision_poller dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .Mario_X_Pos      (Mario_X_Pos),
        .Mario_Y_Pos      (Mario_Y_Pos),
        .Scroll_Offset    (Scroll_Offset),
        .tile_addr        (tile_addr),
        .tile_rd          (tile_rd),
        .tile_data        (tile_data),
        .mario_poll_up    (mario_poll_up),
        .mario_poll_down  (mario_poll_down),
        .mario_poll_left  (mario_poll_left),
        .mario_poll_right (mario_poll_right),
        .poll_done        (poll_done)
    );

    always @(posedge Clk) begin
        if (tile_rd) begin
            tile_data <= mem[tile_addr];
            addr_log.push_back(int'(tile_addr));
        end
        if (poll_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input int got, input int want);
        vec_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // Value one probe sees, straight from the box geometry and level bounds.
    function automatic int probe_val(input int x, input int y, input int sc, input int k);
        int l, r, t, b, px, py, wx;
        l = x - 20; r = x + 19; t = y - 20; b = y + 19;
        case (k)
            0: begin px = l + 2; py = t - 2; end
            1: begin px = r - 2; py = t - 2; end
            2: begin px = l + 2; py = b + 2; end
            3: begin px = r - 2; py = b + 2; end
            4: begin px = l - 2; py = t + 2; end
            5: begin px = l - 2; py = b - 2; end
            6: begin px = r + 2; py = t + 2; end
            default: begin px = r + 2; py = b - 2; end
        endcase
        wx = px + sc;
        if (wx < 0 || wx >= 4096) return 7;
        if (py < 0 || py >= 480) return 0;
        return int'(mem[(py / 16) * 256 + wx / 16]);
    endfunction

    function automatic int model_poll(input int x, input int y, input int sc, input int dir);
        int a;
        a = probe_val(x, y, sc, 2 * dir);
        return (a != 0) ? a : probe_val(x, y, sc, 2 * dir + 1);
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 8192; i++) mem[i] = 3'd0;
    endtask

    task automatic run_sweep(input int x, input int y, input int sc, input bit wiggle, input string tag);
        int n;
        bit got;
        Mario_X_Pos   = 10'(x);
        Mario_Y_Pos   = 10'(y);
        Scroll_Offset = 12'(sc);
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        addr_log.delete();
        frame_clk = 1'b0;
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge Clk);
            #1;
            n++;
            if (wiggle && n == 4) begin
                Mario_X_Pos   = 10'(x + 300);
                Mario_Y_Pos   = 10'(y + 77);
                Scroll_Offset = 12'(sc + 500);
            end
            if (poll_done) got = 1'b1;
        end
        check_eq({tag, "_latency"}, n, 11);
        check_eq({tag, "_reads"}, addr_log.size(), 8);
        check_eq({tag, "_up"},    int'(mario_poll_up),    model_poll(x, y, sc, 0));
        check_eq({tag, "_down"},  int'(mario_poll_down),  model_poll(x, y, sc, 1));
        check_eq({tag, "_left"},  int'(mario_poll_left),  model_poll(x, y, sc, 2));
        check_eq({tag, "_right"}, int'(mario_poll_right), model_poll(x, y, sc, 3));
        $display("sweep %s x=%0d y=%0d scroll=%0d -> up=%0d down=%0d left=%0d right=%0d",
                 tag, x, y, sc, mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right);
        @(posedge Clk);
        #1;
        check_eq({tag, "_done_clear"}, int'(poll_done), 0);
    endtask

    initial begin
        int hold_up, hold_dn, hold_lf, hold_rt, dc;
        clear_mem();
        Reset = 1'b0;
        frame_clk = 1'b0;
        Mario_X_Pos = 10'd0;
        Mario_Y_Pos = 10'd0;
        Scroll_Offset = 12'd0;
        repeat (3) @(posedge Clk);
        #1;
        check_eq("rst_up", int'(mario_poll_up), 0);
        check_eq("rst_down", int'(mario_poll_down), 0);
        check_eq("rst_rd", int'(tile_rd), 0);
        check_eq("rst_addr", int'(tile_addr), 0);
        check_eq("rst_done", int'(poll_done), 0);
        Reset = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        check_eq("no_spurious_done", done_cnt, 0);

        // Left edge of the level
        run_sweep(21, 200, 0, 1'b0, "left_oob");
        check_eq("left_oob_const", int'(mario_poll_left), 7);
        check_eq("left_oob_right0", int'(mario_poll_right), 0);

        // Ground under Mario
        for (int c = 0; c < 40; c++) mem[27 * 256 + c] = 3'd1;
        run_sweep(140, 419, 0, 1'b0, "ground");
        check_eq("ground_addr2", addr_log[2], 6919);
        check_eq("ground_addr3", addr_log[3], 6921);
        check_eq("ground_down_const", int'(mario_poll_down), 1);

        // Scroll moves the probe onto a lone ground tile
        clear_mem();
        mem[27 * 256 + 11] = 3'd1;
        run_sweep(140, 419, 64, 1'b0, "scroll64");
        check_eq("scroll_addr2", addr_log[2], 6923);
        check_eq("scroll64_down_const", int'(mario_poll_down), 1);
        run_sweep(140, 419, 0, 1'b0, "scroll0");
        check_eq("scroll0_down_const", int'(mario_poll_down), 0);

        // Pair priority
        clear_mem();
        mem[4 * 256 + 7] = 3'd2;
        mem[4 * 256 + 9] = 3'd5;
        run_sweep(140, 100, 0, 1'b0, "prio_a");
        check_eq("prio_a_const", int'(mario_poll_up), 2);
        mem[4 * 256 + 7] = 3'd0;
        run_sweep(140, 100, 0, 1'b0, "prio_b");
        check_eq("prio_b_const", int'(mario_poll_up), 5);

        // Inputs moving mid-sweep must not leak into the result
        for (int c = 0; c < 40; c++) mem[27 * 256 + c] = 3'd1;
        run_sweep(140, 419, 0, 1'b1, "snapshot");

        // Reset during probe 3
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        frame_clk = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        check_eq("mid_rd", int'(tile_rd), 1);
        Reset = 1'b0;
        #1;
        check_eq("abort_down", int'(mario_poll_down), 0);
        check_eq("abort_rd", int'(tile_rd), 0);
        check_eq("abort_addr", int'(tile_addr), 0);
        check_eq("abort_done", int'(poll_done), 0);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        dc = done_cnt;
        repeat (20) @(posedge Clk);
        #1;
        check_eq("post_rst_down", int'(mario_poll_down), 0);
        check_eq("post_rst_no_sweep", done_cnt, dc);
        run_sweep(140, 419, 0, 1'b0, "post_rst");

        // Random scenes
        for (int i = 0; i < 8192; i++) mem[i] = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd0;
        for (int s = 0; s < 25; s++) begin
            run_sweep(int'($urandom_range(1023)), int'($urandom_range(1023)),
                      int'($urandom_range(4095)), 1'($urandom_range(1)), $sformatf("rnd%0d", s));
        end

        // Idle hold
        hold_up = int'(mario_poll_up);
        hold_dn = int'(mario_poll_down);
        hold_lf = int'(mario_poll_left);
        hold_rt = int'(mario_poll_right);
        dc = done_cnt;
        Mario_X_Pos = 10'd500;
        repeat (1000) @(posedge Clk);
        #1;
        check_eq("hold_up", int'(mario_poll_up), hold_up);
        check_eq("hold_down", int'(mario_poll_down), hold_dn);
        check_eq("hold_left", int'(mario_poll_left), hold_lf);
        check_eq("hold_right", int'(mario_poll_right), hold_rt);
        check_eq("hold_no_done", done_cnt, dc);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
